rf_wb_arbiter: RTL

- Shares the single register-file write port (RegWre / WriteReg / WriteData) between NUM_REQ write-back requesters, e.g. ALU result and memory load.
- Each requester uses a valid/ready handshake.
- Round-robin arbitration picks one request per cycle into a one-entry registered write stage; that stage drives the RF write port.
- A pipeline hold input freezes the stage. A wrapping write counter supports debug and performance monitoring.

---
 rtl/rf_wb_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/rf_wb_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package rf_wb_pkg;
    localparam int REG_AW  = 5;
    localparam int REG_DW  = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam int GRANT_W = 2;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index; the pointer only
// advances to the winner when the caller reports an actual transfer.
module rr_arbiter
    import rf_wb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               update,
    output logic [NUM_REQ-1:0] grant,
    output logic [GRANT_W-1:0] grantIdx,
    output logic               anyGrant
);
    logic [GRANT_W-1:0] rrPtr;

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!anyGrant && valid[i] && (i == (int'(rrPtr) + k) % NUM_REQ)) begin
                    anyGrant    = 1'b1;
                    grant[i]    = 1'b1;
                    grantIdx    = GRANT_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rrPtr <= GRANT_W'(NUM_REQ - 1);
        else if (update)
            rrPtr <= grantIdx;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the RF write port between NUM_REQ write-back requesters via a one-entry
// registered write stage. Optional same-cycle read forwarding: RF_WB_BYPASS_EN.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW      = REG_AW,
    parameter int DW      = REG_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    input  logic                  wb_hold,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_waddr,
    output logic [DW-1:0]         rf_wdata,
    output logic                  stage_valid,
    output logic [GRANT_W-1:0]    grant_id,
    output logic [15:0]           wr_count
`ifdef RF_WB_BYPASS_EN
   ,input  logic [AW-1:0]         rd_addr1,
    input  logic [AW-1:0]         rd_addr2,
    input  logic [DW-1:0]         rf_rdata1,
    input  logic [DW-1:0]         rf_rdata2,
    output logic [DW-1:0]         fwd_data1,
    output logic [DW-1:0]         fwd_data2
`endif
);
    logic [NUM_REQ-1:0] grant;
    logic [GRANT_W-1:0] grantIdx;
    logic               anyGrant;
    logic               canAccept;
    logic               retire;
    logic               xfer;
    logic [AW-1:0]      selAddr;
    logic [DW-1:0]      selData;

    assign canAccept = !stage_valid || !wb_hold;
    assign retire    = stage_valid && !wb_hold;
    assign xfer      = rst_n && canAccept && anyGrant;
    assign req_ready = (rst_n && canAccept) ? grant : '0;
    assign rf_we     = rst_n && retire && (rf_waddr != AW'(REG_ZERO));

    rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (req_valid),
        .update   (xfer),
        .grant    (grant),
        .grantIdx (grantIdx),
        .anyGrant (anyGrant)
    );

    // One-hot AND-OR mux of the winning request's payload.
    always_comb begin
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                selAddr = selAddr | req_addr[i*AW +: AW];
                selData = selData | req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            grant_id    <= '0;
        end else if (xfer) begin
            stage_valid <= 1'b1;
            rf_waddr    <= selAddr;
            rf_wdata    <= selData;
            grant_id    <= grantIdx;
        end else if (retire) begin
            stage_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wr_count <= '0;
        else if (rf_we)
            wr_count <= wr_count + 16'd1;
    end

`ifdef RF_WB_BYPASS_EN
    // rf_we already excludes register 0, so it is never forwarded.
    assign fwd_data1 = (rf_we && (rd_addr1 == rf_waddr)) ? rf_wdata : rf_rdata1;
    assign fwd_data2 = (rf_we && (rd_addr2 == rf_waddr)) ? rf_wdata : rf_rdata2;
`endif
endmodule
